wb_mem_slave: RTL and testbench

//  Parametrised Wishbone B3 classic-cycle slave backed by a byte-lane RAM, for bus-level tests.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_mem_array.sv | 26 ++
 rtl/wb_mem_slave.sv | 168 ++++++++++++++++
 tb/tb_wb_mem_slave.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone memory slave: FSM states,
// response kinds and a constant-foldable ceil(log2) for address shifts.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_state_e;

  typedef enum {
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } wb_rsp_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Word-organised RAM with one write enable per byte lane; writes land on the
// rising edge, reads are combinational from the addressed word.
module wb_mem_array #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                  clk_i,
  input  logic [DWIDTH/8-1:0]   be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DWIDTH-1:0]     wdat_i,
  output logic [DWIDTH-1:0]     rdat_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; clearing them would force a flop-based array and its contents are undefined after reset anyway.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DWIDTH / 8; b++) begin
      if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
    end
  end

  assign rdat_o = mem_q[addr_i];

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic-cycle memory target with programmable wait states,
// byte-lane writes, out-of-range ERR, periodic RTY and cycle abort.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int RTY_EVERY   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [AWIDTH-1:0]     adr_i,
  input  logic [DWIDTH-1:0]     dat_i,
  input  logic                  we_i,
  input  logic [DWIDTH/8-1:0]   sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic [DWIDTH-1:0]     dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o
);

  localparam int SEL   = DWIDTH / 8;
  localparam int SHIFT = clog2(SEL);
  localparam int MAW   = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] DEPTH_L  = (AWIDTH + 1)'(DEPTH);
  localparam logic [3:0]      WS_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [15:0]     RTY_LAST = (RTY_EVERY > 0) ? 16'(RTY_EVERY - 1) : 16'd0;

  wb_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       rty_cnt_q, rty_cnt_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [DWIDTH-1:0] wdat_q, wdat_d;
  logic              we_q, we_d;
  logic [SEL-1:0]    sel_q, sel_d;
  logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [DWIDTH-1:0] rdat_q, rdat_d;

  logic [AWIDTH-1:0] req_idx;
  logic [DWIDTH-1:0] req_dat;
  logic              req_we;
  logic [SEL-1:0]    req_sel;
  logic              go_resp, rty_hit;
  wb_rsp_e           rsp;
  logic [SEL-1:0]    mem_be;
  logic [DWIDTH-1:0] mem_rdat;

  // With no wait states the response is decided on the accept edge, so the
  // live bus is used in IDLE and the latched request everywhere else.
  always_comb begin
    req_idx = (state_q == IDLE) ? (adr_i >> SHIFT) : idx_q;
    req_dat = (state_q == IDLE) ? dat_i : wdat_q;
    req_we  = (state_q == IDLE) ? we_i : we_q;
    req_sel = (state_q == IDLE) ? sel_i : sel_q;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rty_cnt_d = rty_cnt_q;
    idx_d     = idx_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    rdat_d    = '0;
    go_resp   = 1'b0;
    rty_hit   = 1'b0;
    rsp       = RSP_ACK;
    mem_be    = '0;

    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          idx_d  = adr_i >> SHIFT;
          wdat_d = dat_i;
          we_d   = we_i;
          sel_d  = sel_i;
          if (WAIT_STATES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (!cyc_i)            state_d = IDLE;
        else if (cnt_q == 4'd0) go_resp = 1'b1;
        else                   cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_resp) begin
      state_d = RESP;
      rty_hit = (RTY_EVERY > 0) && (rty_cnt_q == RTY_LAST);
      if (RTY_EVERY > 0) rty_cnt_d = rty_hit ? 16'd0 : rty_cnt_q + 16'd1;
      if ({1'b0, req_idx} >= DEPTH_L) rsp = RSP_ERR;
      else if (rty_hit)               rsp = RSP_RTY;
      else                            rsp = RSP_ACK;
      case (rsp)
        RSP_ERR: err_d = 1'b1;
        RSP_RTY: rty_d = 1'b1;
        default: begin
          ack_d = 1'b1;
          if (req_we) mem_be = req_sel;
          else        rdat_d = mem_rdat;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rty_cnt_q <= '0;
      idx_q     <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rty_cnt_q <= rty_cnt_d;
      idx_q     <= idx_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      rdat_q    <= rdat_d;
    end
  end

  wb_mem_array #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (MAW)
  ) u_mem (
    .clk_i  (clk_i),
    .be_i   (mem_be),
    .addr_i (req_idx[MAW-1:0]),
    .wdat_i (req_dat),
    .rdat_o (mem_rdat)
  );

  assign dat_o = rdat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = rty_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: five instances with different parameter
// sets share the bus wires and are selected individually through cyc.
module tb_wb_mem_slave;

  logic        clk, rst_n;
  logic [15:0] adr;
  logic [31:0] wdat;
  logic        we, stb;
  logic [3:0]  sel;
  logic [4:0]  cyc;
  wire  [4:0]  ack, err, rty;
  wire  [31:0] rdat0, rdat1, rdat2, rdat3;
  wire  [7:0]  rdat8;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  logic [2:0]  term;
  logic [31:0] rd;

  localparam logic [2:0] T_ACK = 3'b001;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b100;

  // 0: W=0  1: W=3  2: RTY_EVERY=3  3: W=5  (all 32-bit)   4: 8-bit, DEPTH=256
  wb_mem_slave #(.DWIDTH(32), .AWIDTH(16), .DEPTH(256), .WAIT_STATES(0), .RTY_EVERY(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat), .we_i(we), .sel_i(sel), .stb_i(stb),
    .cyc_i(cyc[0]), .dat_o(rdat0), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]));
  wb_mem_slave #(.DWIDTH(32), .AWIDTH(16), .DEPTH(256), .WAIT_STATES(3), .RTY_EVERY(0)) u_b (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat), .we_i(we), .sel_i(sel), .stb_i(stb),
    .cyc_i(cyc[1]), .dat_o(rdat1), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]));
  wb_mem_slave #(.DWIDTH(32), .AWIDTH(16), .DEPTH(256), .WAIT_STATES(0), .RTY_EVERY(3)) u_d (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat), .we_i(we), .sel_i(sel), .stb_i(stb),
    .cyc_i(cyc[2]), .dat_o(rdat2), .ack_o(ack[2]), .err_o(err[2]), .rty_o(rty[2]));
  wb_mem_slave #(.DWIDTH(32), .AWIDTH(16), .DEPTH(256), .WAIT_STATES(5), .RTY_EVERY(0)) u_e (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat), .we_i(we), .sel_i(sel), .stb_i(stb),
    .cyc_i(cyc[3]), .dat_o(rdat3), .ack_o(ack[3]), .err_o(err[3]), .rty_o(rty[3]));
  wb_mem_slave #(.DWIDTH(8), .AWIDTH(16), .DEPTH(256), .WAIT_STATES(0), .RTY_EVERY(0)) u_c (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat[7:0]), .we_i(we), .sel_i(sel[0]), .stb_i(stb),
    .cyc_i(cyc[4]), .dat_o(rdat8), .ack_o(ack[4]), .err_o(err[4]), .rty_o(rty[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd_of(input int i);
    case (i)
      0:       return rdat0;
      1:       return rdat1;
      2:       return rdat2;
      3:       return rdat3;
      default: return {24'h0, rdat8};
    endcase
  endfunction

  // Called at a negedge; drives one request on instance i and waits for a
  // termination, returning cycles to response, {rty,err,ack} and dat_o.
  task automatic xfer(input int i, input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int l, output logic [2:0] t, output logic [31:0] r);
    adr = a; wdat = d; we = w; sel = s; stb = 1'b1; cyc = 5'b00001 << i;
    l = 0; t = 3'b000; r = '0;
    while (t == 3'b000 && l < 40) begin
      @(negedge clk);
      l++;
      t = {rty[i], err[i], ack[i]};
      r = rd_of(i);
    end
    stb = 1'b0; cyc = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ack, err, rty} !== 15'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0", {ack, err, rty}); end
    n_cmp++; if ({rdat0, rdat1, rdat2, rdat3, rdat8} !== '0) begin n_bad++; $display("FAIL rst_dat: got nonzero dat_o"); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ack, err, rty} !== 15'b0) begin n_bad++; $display("FAIL idle_flags: got %b want 0", {ack, err, rty}); end
  endtask

  task automatic test_write_read;
    xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, lat, term, rd);
    n_cmp++; if (term !== T_ACK) begin n_bad++; $display("FAIL wr_term: got %b want %b", term, T_ACK); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_lat: got %0d want 1", lat); end
    @(negedge clk);
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, lat, term, rd);
    n_cmp++; if (term !== T_ACK || lat !== 1) begin n_bad++; $display("FAIL rd_term_lat: got %b/%0d want %b/1", term, lat, T_ACK); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    @(negedge clk);
    n_cmp++; if (rdat0 !== 32'h0) begin n_bad++; $display("FAIL dat_idle: got %h want 0", rdat0); end
  endtask

  task automatic test_byte_lanes;
    xfer(0, 1'b1, 16'h0020, 32'h11223344, 4'hF, lat, term, rd);
    xfer(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, lat, term, rd);
    n_cmp++; if (term !== T_ACK) begin n_bad++; $display("FAIL sel_wr_term: got %b want %b", term, T_ACK); end
    xfer(0, 1'b0, 16'h0023, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL sel_merge: got %h want 11bb33dd", rd); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_lat: got %0d want 2", lat); end
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    xfer(1, 1'b1, 16'h0040, 32'hCAFEF00D, 4'hF, lat, term, rd);
    n_cmp++; if (term !== T_ACK || lat !== 4) begin n_bad++; $display("FAIL ws_wr: got %b/%0d want %b/4", term, lat, T_ACK); end
    @(negedge clk);
    adr = 16'h0040; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 5'b00010; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[1] && lat < 40);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws_rd_lat: got %0d want 4", lat); end
    n_cmp++; if (rdat1 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ws_rd_data: got %h want cafef00d", rdat1); end
    @(negedge clk);
    n_cmp++; if (ack[1] !== 1'b0) begin n_bad++; $display("FAIL ack_width: got %b want 0", ack[1]); end
    stb = 1'b0; cyc = '0;
    @(negedge clk);
  endtask

  task automatic test_range_err;
    xfer(4, 1'b1, 16'h0000, 32'h11, 4'h1, lat, term, rd);
    @(negedge clk);
    xfer(4, 1'b1, 16'h0100, 32'h99, 4'h1, lat, term, rd);
    n_cmp++; if (term !== T_ERR) begin n_bad++; $display("FAIL err_wr_term: got %b want %b", term, T_ERR); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_dat: got %h want 0", rd); end
    @(negedge clk);
    xfer(4, 1'b1, 16'h00FF, 32'h5A, 4'h1, lat, term, rd);
    @(negedge clk);
    xfer(4, 1'b0, 16'h00FF, 32'h0, 4'h0, lat, term, rd);
    n_cmp++; if (term !== T_ACK || rd !== 32'h5A) begin n_bad++; $display("FAIL top_word: got %b/%h want %b/5a", term, rd, T_ACK); end
    @(negedge clk);
    xfer(4, 1'b0, 16'h0000, 32'h0, 4'h0, lat, term, rd);
    n_cmp++; if (rd !== 32'h11) begin n_bad++; $display("FAIL no_alias: got %h want 11", rd); end
    @(negedge clk);
    xfer(4, 1'b0, 16'hFFFF, 32'h0, 4'h0, lat, term, rd);
    n_cmp++; if (term !== T_ERR) begin n_bad++; $display("FAIL err_rd_term: got %b want %b", term, T_ERR); end
    @(negedge clk);
  endtask

  task automatic test_retry;
    logic [2:0] exp_t;
    xfer(2, 1'b1, 16'h0008, 32'hA2A2A2A2, 4'hF, lat, term, rd);
    xfer(2, 1'b1, 16'h0014, 32'hA5A5A5A5, 4'hF, lat, term, rd);
    xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (term !== T_RTY) begin n_bad++; $display("FAIL rty_pre: got %b want %b", term, T_RTY); end
    for (int k = 0; k < 6; k++) begin
      exp_t = (k == 2 || k == 5) ? T_RTY : T_ACK;
      xfer(2, 1'b1, 16'(k * 4), 32'h1000 + 32'(k), 4'hF, lat, term, rd);
      n_cmp++; if (term !== exp_t) begin n_bad++; $display("FAIL rty_seq%0d: got %b want %b", k, term, exp_t); end
    end
    xfer(2, 1'b0, 16'h0008, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (rd !== 32'hA2A2A2A2) begin n_bad++; $display("FAIL rty_keep2: got %h want a2a2a2a2", rd); end
    xfer(2, 1'b0, 16'h0014, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL rty_keep5: got %h want a5a5a5a5", rd); end
    xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (term !== T_RTY || rd !== 32'h0) begin n_bad++; $display("FAIL rty_rd: got %b/%h want %b/0", term, rd, T_RTY); end
    xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (rd !== 32'h1000) begin n_bad++; $display("FAIL rty_w0: got %h want 1000", rd); end
    xfer(2, 1'b0, 16'h000C, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (rd !== 32'h1003) begin n_bad++; $display("FAIL rty_w3: got %h want 1003", rd); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic seen;
    xfer(3, 1'b1, 16'h0008, 32'h12345678, 4'hF, lat, term, rd);
    n_cmp++; if (term !== T_ACK || lat !== 6) begin n_bad++; $display("FAIL ws5_wr: got %b/%0d want %b/6", term, lat, T_ACK); end
    @(negedge clk);
    adr = 16'h0008; wdat = 32'hFFFFFFFF; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 5'b01000;
    repeat (2) @(negedge clk);
    stb = 1'b0; cyc = '0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack[3] || err[3] || rty[3]) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: got response want none"); end
    xfer(3, 1'b0, 16'h0008, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (term !== T_ACK || lat !== 6) begin n_bad++; $display("FAIL abort_next: got %b/%0d want %b/6", term, lat, T_ACK); end
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL abort_mem: got %h want 12345678", rd); end
    @(negedge clk);
  endtask

  task automatic test_reset_async;
    xfer(3, 1'b0, 16'h0008, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (ack[3] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_ack: got %b want 1", ack[3]); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ack[3] !== 1'b0 || rdat3 !== 32'h0) begin n_bad++; $display("FAIL rst_async: got %b/%h want 0/0", ack[3], rdat3); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    adr = 16'h0008; wdat = 32'h0; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 5'b01000;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ack, err, rty} !== 15'b0 || rdat3 !== 32'h0) begin n_bad++; $display("FAIL rst_wait: got %b want 0", {ack, err, rty}); end
    stb = 1'b0; cyc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(3, 1'b0, 16'h0008, 32'h0, 4'hF, lat, term, rd);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL rst_discard: got %h want 12345678", rd); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_range_err();
    test_retry();
    test_abort();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
